// File: rtl/mem_pkg.sv
// Shared definitions for the data memory slice.
//   - RV64 load/store funct3 codes
//   - FSM state enum
//   - access-size / byte-lane widths and a size-to-byte-mask helper
package mem_pkg;

  // Load codes; store codes reuse 000..011 (SB/SH/SW/SD).
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  localparam int SIZE_W = 2;  // log2(bytes) access-size code, funct3[1:0]
  localparam int LANE_W = 3;  // byte lane within a doubleword
  localparam int BE_W   = 8;  // one enable per byte of a doubleword

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Byte-enable pattern for an access of 2**size bytes starting at lane 0.
  function automatic logic [BE_W-1:0] size_mask(input logic [SIZE_W-1:0] size);
    case (size)
      2'd0:    size_mask = 8'h01;
      2'd1:    size_mask = 8'h03;
      2'd2:    size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Load alignment: selects the addressed bytes of a doubleword and
// sign- or zero-extends them according to funct3.
//   word   : full 64-bit doubleword read from storage
//   lane   : byte offset of the access within the doubleword
//   funct3 : RV64 load code
//   data   : right-aligned, extended load result
module load_align
  import mem_pkg::*;
(
  input  logic [63:0]       word,
  input  logic [LANE_W-1:0] lane,
  input  logic [2:0]        funct3,
  output logic [63:0]       data
);

  logic [63:0] shifted;

  always_comb begin
    // Little-endian: the addressed byte moves down to bit 0.
    shifted = word >> {lane, 3'b000};
    case (funct3)
      F3_B:    data = {{56{shifted[7]}},  shifted[7:0]};
      F3_H:    data = {{48{shifted[15]}}, shifted[15:0]};
      F3_W:    data = {{32{shifted[31]}}, shifted[31:0]};
      F3_BU:   data = {56'd0, shifted[7:0]};
      F3_HU:   data = {48'd0, shifted[15:0]};
      F3_WU:   data = {32'd0, shifted[31:0]};
      default: data = shifted;
    endcase
  end

endmodule

// File: rtl/data_memory.sv
// Single-outstanding load/store data memory with a fixed response latency.
//   clk, reset                      : clock, synchronous active-high reset
//   req_valid/req_ready             : request handshake (ready only when idle)
//   req_write/req_funct3/req_addr/req_wdata : request fields, captured at accept
//   rsp_valid/rsp_ready             : response handshake
//   rsp_rdata/rsp_err               : load result (0 for stores/errors), error flag
module data_memory
  import mem_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [63:0] LIMIT    = 64'(DEPTH) * 64'd8;
  localparam logic [3:0]  CNT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  state_t      state_reg;
  logic [3:0]  cnt_reg;
  logic        write_reg;
  logic [2:0]  funct3_reg;
  logic [63:0] addr_reg;
  logic [63:0] wdata_reg;
  logic [63:0] rsp_rdata_reg;
  logic        rsp_err_reg;

  logic [63:0] mem [DEPTH];

  logic              accept;
  logic              enter_resp;
  logic              op_write;
  logic [2:0]        op_funct3;
  logic [63:0]       op_addr;
  logic [63:0]       op_wdata;
  logic [SIZE_W-1:0] op_size;
  logic [LANE_W-1:0] op_lane;
  logic [AW-1:0]     op_idx;
  logic              misaligned;
  logic              out_of_range;
  logic              bad_funct3;
  logic              op_err;
  logic [BE_W-1:0]   byte_en;
  logic [63:0]       wdata_shifted;
  logic [63:0]       rd_word;
  logic [63:0]       load_data;

  assign req_ready = (state_reg == ST_IDLE);
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (state_reg == ST_RESP);
  assign rsp_rdata = rsp_rdata_reg;
  assign rsp_err   = rsp_err_reg;

  // With LATENCY=0 the access completes on the accept edge itself, before
  // the capture registers hold the request, so in IDLE the live inputs are
  // used. Every other completion happens from BUSY using captured fields.
  assign op_write  = (state_reg == ST_IDLE) ? req_write  : write_reg;
  assign op_funct3 = (state_reg == ST_IDLE) ? req_funct3 : funct3_reg;
  assign op_addr   = (state_reg == ST_IDLE) ? req_addr   : addr_reg;
  assign op_wdata  = (state_reg == ST_IDLE) ? req_wdata  : wdata_reg;

  assign enter_resp = ((state_reg == ST_IDLE) && accept && (LATENCY == 0)) ||
                      ((state_reg == ST_BUSY) && (cnt_reg == 4'd0));

  assign op_size = op_funct3[1:0];
  assign op_lane = op_addr[2:0];
  assign op_idx  = op_addr[AW+2:3];

  always_comb begin
    case (op_size)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = op_lane[0];
      2'd2:    misaligned = |op_lane[1:0];
      default: misaligned = |op_lane;
    endcase
  end

  assign out_of_range  = (op_addr >= LIMIT);
  // Stores have no unsigned variants; loads reserve only 111.
  assign bad_funct3    = op_write ? op_funct3[2] : (op_funct3 == 3'b111);
  assign op_err        = misaligned || out_of_range || bad_funct3;

  assign byte_en       = size_mask(op_size) << op_lane;
  assign wdata_shifted = op_wdata << {op_lane, 3'b000};
  assign rd_word       = mem[op_idx];

  load_align u_load_align (
    .word   (rd_word),
    .lane   (op_lane),
    .funct3 (op_funct3),
    .data   (load_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= 4'd0;
      write_reg     <= 1'b0;
      funct3_reg    <= 3'd0;
      addr_reg      <= 64'd0;
      wdata_reg     <= 64'd0;
      rsp_rdata_reg <= 64'd0;
      rsp_err_reg   <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            write_reg  <= req_write;
            funct3_reg <= req_funct3;
            addr_reg   <= req_addr;
            wdata_reg  <= req_wdata;
            if (LATENCY == 0) begin
              state_reg <= ST_RESP;
            end else begin
              state_reg <= ST_BUSY;
              cnt_reg   <= CNT_LOAD;
            end
          end
        end
        ST_BUSY: begin
          if (cnt_reg == 4'd0) state_reg <= ST_RESP;
          else                 cnt_reg   <= cnt_reg - 4'd1;
        end
        ST_RESP: begin
          if (rsp_ready) state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase

      // Response fields are frozen from here until the handshake.
      if (enter_resp) begin
        rsp_err_reg   <= op_err;
        rsp_rdata_reg <= (op_err || op_write) ? 64'd0 : load_data;
      end
    end
  end

  // Storage is not reset; a commit coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (!reset && enter_resp && op_write && !op_err) begin
      for (int b = 0; b < BE_W; b++) begin
        if (byte_en[b]) mem[op_idx][8*b +: 8] <= wdata_shifted[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_memory.sv
module tb_data_memory;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;

  // LATENCY=2 instance
  logic        req_valid, req_ready, rsp_valid, rsp_ready, rsp_err;
  logic [63:0] rsp_rdata;
  // LATENCY=0 instance
  logic        req_valid_z, req_ready_z, rsp_valid_z, rsp_ready_z, rsp_err_z;
  logic [63:0] rsp_rdata_z;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  data_memory #(.DEPTH(256), .LATENCY(2)) u_dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  data_memory #(.DEPTH(256), .LATENCY(0)) u_dut_z (
    .clk(clk), .reset(reset),
    .req_valid(req_valid_z), .req_ready(req_ready_z),
    .req_write(req_write), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_z), .rsp_ready(rsp_ready_z),
    .rsp_rdata(rsp_rdata_z), .rsp_err(rsp_err_z)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, got, exp);
  endtask

  // One full transaction; lat counts negedges after the accept edge until
  // rsp_valid is seen (99 if it never arrives within the budget).
  task automatic do_req(input bit z, input logic wr, input logic [2:0] f3,
                        input logic [63:0] a, input logic [63:0] wd,
                        output int lat, output logic [63:0] rd, output logic err);
    @(negedge clk);
    req_write = wr; req_funct3 = f3; req_addr = a; req_wdata = wd;
    if (z) req_valid_z = 1'b1; else req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; req_valid_z = 1'b0;
    lat = 99;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if ((z ? rsp_valid_z : rsp_valid) === 1'b1) begin
        lat = n;
        break;
      end
    end
    rd  = z ? rsp_rdata_z : rsp_rdata;
    err = z ? rsp_err_z : rsp_err;
    $display("txn dut=%0d wr=%0d f3=%0d addr=%h wdata=%h -> lat=%0d rdata=%h err=%0d",
             z ? 0 : 2, wr, f3, a, wd, lat, rd, err);
    if (z) rsp_ready_z = 1'b1; else rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0; rsp_ready_z = 1'b0;
  endtask

  initial begin
    int          lat;
    logic [63:0] rd;
    logic        err;
    logic        saw_valid;

    reset = 1'b1;
    req_valid = 1'b0; req_valid_z = 1'b0;
    rsp_ready = 1'b0; rsp_ready_z = 1'b0;
    req_write = 1'b0; req_funct3 = 3'd0; req_addr = 64'd0; req_wdata = 64'd0;
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b0;

    // Reset state
    check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check("rst_req_ready", {63'd0, req_ready}, 64'd1);
    check("rst_rsp_err",   {63'd0, rsp_err},   64'd0);
    check("rst_rsp_rdata", rsp_rdata,          64'd0);

    // Doubleword store then load
    do_req(0, 1'b1, F3_D, 64'h10, 64'h8877665544332211, lat, rd, err);
    check("sd_lat", 64'(lat), 64'd3);
    check("sd_err", {63'd0, err}, 64'd0);
    check("sd_rdata", rd, 64'd0);
    do_req(0, 1'b0, F3_D, 64'h10, 64'd0, lat, rd, err);
    check("ld_lat", 64'(lat), 64'd3);
    check("ld_rdata", rd, 64'h8877665544332211);
    check("ld_err", {63'd0, err}, 64'd0);

    // Sub-word loads with extension
    do_req(0, 1'b0, F3_B,  64'h17, 64'd0, lat, rd, err);
    check("lb_17", rd, 64'hFFFFFFFFFFFFFF88);
    do_req(0, 1'b0, F3_BU, 64'h17, 64'd0, lat, rd, err);
    check("lbu_17", rd, 64'h88);
    do_req(0, 1'b0, F3_H,  64'h12, 64'd0, lat, rd, err);
    check("lh_12", rd, 64'h4433);
    do_req(0, 1'b0, F3_H,  64'h16, 64'd0, lat, rd, err);
    check("lh_16", rd, 64'hFFFFFFFFFFFF8877);
    do_req(0, 1'b0, F3_W,  64'h14, 64'd0, lat, rd, err);
    check("lw_14", rd, 64'hFFFFFFFF88776655);
    do_req(0, 1'b0, F3_WU, 64'h14, 64'd0, lat, rd, err);
    check("lwu_14", rd, 64'h88776655);

    // Byte store leaves other bytes intact
    do_req(0, 1'b1, F3_B, 64'h11, 64'hFFFFFFFFFFFFFFAB, lat, rd, err);
    check("sb_err", {63'd0, err}, 64'd0);
    do_req(0, 1'b0, F3_D, 64'h10, 64'd0, lat, rd, err);
    check("ld_after_sb", rd, 64'h887766554433AB11);

    // Error cases: same latency, rdata 0, no write
    do_req(0, 1'b0, F3_W, 64'h12, 64'd0, lat, rd, err);
    check("lw_mis_err", {63'd0, err}, 64'd1);
    check("lw_mis_rdata", rd, 64'd0);
    check("lw_mis_lat", 64'(lat), 64'd3);
    do_req(0, 1'b1, F3_H, 64'h13, 64'hFFFF, lat, rd, err);
    check("sh_mis_err", {63'd0, err}, 64'd1);
    do_req(0, 1'b0, F3_D, 64'h800, 64'd0, lat, rd, err);
    check("ld_oor_err", {63'd0, err}, 64'd1);
    check("ld_oor_rdata", rd, 64'd0);
    do_req(0, 1'b0, 3'b111, 64'h10, 64'd0, lat, rd, err);
    check("ld_f3_7_err", {63'd0, err}, 64'd1);
    do_req(0, 1'b1, F3_BU, 64'h10, 64'h55, lat, rd, err);
    check("st_f3_4_err", {63'd0, err}, 64'd1);
    do_req(0, 1'b0, F3_D, 64'h10, 64'd0, lat, rd, err);
    check("ld_after_err", rd, 64'h887766554433AB11);

    // Back-pressure: response held stable, no new accept
    @(negedge clk);
    req_write = 1'b0; req_funct3 = F3_D; req_addr = 64'h10; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 99;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin lat = n; break; end
    end
    check("stall_lat", 64'(lat), 64'd3);
    // A competing request during the stall must not be taken.
    req_addr = 64'h18; req_funct3 = F3_B; req_valid = 1'b1;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      check("stall_valid", {63'd0, rsp_valid}, 64'd1);
      check("stall_rdata", rsp_rdata, 64'h887766554433AB11);
      check("stall_ready", {63'd0, req_ready}, 64'd0);
    end
    req_valid = 1'b0;
    $display("txn dut=2 stalled load addr=0000000000000010 rdata=%h", rsp_rdata);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    check("stall_release_ready", {63'd0, req_ready}, 64'd1);

    // LATENCY=0 instance
    do_req(1, 1'b1, F3_D, 64'h8, 64'h0123456789ABCDEF, lat, rd, err);
    check("z_sd_lat", 64'(lat), 64'd1);
    do_req(1, 1'b0, F3_D, 64'h8, 64'd0, lat, rd, err);
    check("z_ld_lat", 64'(lat), 64'd1);
    check("z_ld_rdata", rd, 64'h0123456789ABCDEF);
    do_req(1, 1'b0, F3_HU, 64'hE, 64'd0, lat, rd, err);
    check("z_lhu_e", rd, 64'h0123);

    // Reset mid-operation drops a pending store
    do_req(0, 1'b1, F3_D, 64'h20, 64'h5555, lat, rd, err);
    check("sd20_err", {63'd0, err}, 64'd0);
    @(negedge clk);
    req_write = 1'b1; req_funct3 = F3_D; req_addr = 64'h20; req_wdata = 64'h1;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    saw_valid = 1'b0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      saw_valid = saw_valid | (rsp_valid === 1'b1);
    end
    $display("txn dut=2 reset during store addr=0000000000000020 saw_valid=%0d", saw_valid);
    check("rst_mid_no_valid", {63'd0, saw_valid}, 64'd0);
    check("rst_mid_ready", {63'd0, req_ready}, 64'd1);
    do_req(0, 1'b0, F3_D, 64'h20, 64'd0, lat, rd, err);
    check("rst_mid_mem", rd, 64'h5555);
    check("rst_mid_lat", 64'(lat), 64'd3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/data_memory.md
DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 The block SHALL have parameter DEPTH, default 256, number of 64-bit doublewords stored (2 KB).
REQ-002 The block SHALL have parameter LATENCY, default 2, wait cycles between accept and response (legal 0..15).
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, all state updates on rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port req_valid, input, 1 bit: the processor presents a load/store request.
REQ-006 The block SHALL have port req_ready, output, 1 bit: the block can accept a request this cycle.
REQ-007 The block SHALL have port req_write, input, 1 bit: 1 = store, 0 = load.
REQ-008 The block SHALL have port req_funct3, input, 3 bits: RV64 size/sign code (LB/LH/LW/LD/LBU/LHU/LWU = 000/001/010/011/100/101/110; SB/SH/SW/SD = 000..011).
REQ-009 The block SHALL have port req_addr, input, 64 bits: byte address.
REQ-010 The block SHALL have port req_wdata, input, 64 bits: store data, right-aligned in the low bits.
REQ-011 The block SHALL have port rsp_valid, output, 1 bit: response available.
REQ-012 The block SHALL have port rsp_ready, input, 1 bit: the processor consumes the response.
REQ-013 The block SHALL have port rsp_rdata, output, 64 bits: load result, extended per funct3; 0 for stores and errors.
REQ-014 The block SHALL have port rsp_err, output, 1 bit: the request was rejected (misaligned, out of range, or illegal funct3).

Function
REQ-015 The FSM SHALL have states IDLE, BUSY and RESP; req_ready SHALL be 1 only in IDLE.
REQ-016 Accept SHALL occur on req_valid && req_ready; write, funct3, addr and wdata SHALL be captured at accept.
REQ-017 On accept, the FSM SHALL go IDLE->BUSY with the wait counter loaded to LATENCY-1; if LATENCY=0, it SHALL go IDLE->RESP directly.
REQ-018 In BUSY, the counter SHALL decrement each cycle; at 0 the FSM SHALL go BUSY->RESP, so rsp_valid rises LATENCY+1 cycles after the accept edge.
REQ-019 In RESP, rsp_valid, rsp_rdata and rsp_err SHALL stay stable until rsp_ready; on rsp_valid && rsp_ready the FSM SHALL go RESP->IDLE.
REQ-020 A new request SHALL be accepted no earlier than the cycle after the handshake, giving one outstanding request.
REQ-021 Word index SHALL be addr[3+log2(DEPTH)-1:3] and byte lane SHALL be addr[2:0], little-endian within the doubleword.
REQ-022 A store SHALL commit on the edge entering RESP and write only the addressed bytes (1/2/4/8 per funct3); other bytes SHALL be unchanged.
REQ-023 Load data SHALL be sampled on the edge entering RESP.
REQ-024 Load extension: LB/LH/LW SHALL sign-extend, LBU/LHU/LWU SHALL zero-extend, and LD SHALL return the full doubleword.
REQ-025 Errors: addr not aligned to the access size; addr >= DEPTH*8; load funct3=111; store funct3[2]=1.
REQ-026 On error: rsp_err=1, rsp_rdata=0, no memory write, same latency as a legal access.
REQ-027 Request inputs SHALL be ignored outside accept cycles.

Reset
REQ-028 On reset: FSM=IDLE, counter=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, req_ready=1 from the next cycle.
REQ-029 Reset mid-operation SHALL drop the pending request; a store not yet committed SHALL NOT write.
REQ-030 Memory contents SHALL NOT be altered by reset.

Structure
REQ-031 A shared package mem_pkg SHALL hold the funct3 constants, the FSM state enum, and the access-size helper constant widths.
REQ-032 Combinational sub-module load_align SHALL perform lane select plus sign/zero extension; store byte-enable generation SHALL remain in data_memory.
REQ-033 Storage SHALL be one DEPTH x 64 register array, written only in data_memory.

Verification
REQ-034 LATENCY=2, SD addr 0x10 wdata 0x8877665544332211, then LD 0x10 -> rsp_valid 3 cycles after each accept, rdata 0x8877665544332211, err 0.
REQ-035 After REQ-034: LB 0x17 -> 0xFFFFFFFFFFFFFF88; LBU 0x17 -> 0x88; LH 0x12 -> 0x4433; LW 0x14 -> 0xFFFFFFFF88776655; LWU 0x14 -> 0x88776655.
REQ-036 SB 0x11 wdata 0xAB, then LD 0x10 -> 0x887766554433AB11, proving other bytes are unchanged.
REQ-037 LW 0x12, SH 0x13, LD 0x800 (DEPTH=256), and load funct3=111 -> each gives err=1, rdata=0, no memory change (LD 0x10 still returns the prior value).
REQ-038 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid/rdata stable, req_ready=0; with LATENCY=0 -> rsp_valid the cycle after accept.
REQ-039 Assert reset one cycle after accepting SD 0x20 wdata 0x1 -> rsp_valid never rises, req_ready=1 after reset, LD 0x20 returns the prior contents.
